// File: rtl/gecko_mem_arbiter_pkg.sv
// gecko: shared types for the gecko memory arbiter slice
package gecko;
  typedef enum logic {
    GECKO_MEM_SRC_INST = 1'b0,
    GECKO_MEM_SRC_DATA = 1'b1
  } gecko_mem_src_t;
  localparam int GECKO_MEM_DATA_W = 32;
  localparam int GECKO_MEM_BE_W = 4;
  function automatic gecko_mem_src_t rr_pick(gecko_mem_src_t last, logic inst_v, logic data_v);
    if (inst_v && data_v)
      return (last == GECKO_MEM_SRC_DATA) ? GECKO_MEM_SRC_INST : GECKO_MEM_SRC_DATA;
    if (data_v)
      return GECKO_MEM_SRC_DATA;
    return GECKO_MEM_SRC_INST;
  endfunction
endpackage

// File: rtl/gecko_mem_tag_fifo.sv
// gecko_mem_tag_fifo: in-order source-tag fifo tracking outstanding memory requests
module gecko_mem_tag_fifo
  import gecko::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic empty,
  output logic full
);
  localparam int PW = $clog2(DEPTH);
  logic tags [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) tags[wr_ptr] <= push_tag;
  always_comb begin
    head_tag = tags[rd_ptr];
    empty = count == '0;
    full = count == (PW+1)'(DEPTH);
  end
endmodule

// File: rtl/gecko_mem_arbiter.sv
// gecko_mem_arbiter: round-robin merge of inst/data requests onto one in-order memory port
module gecko_mem_arbiter
  import gecko::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_request_valid,
  output logic                    inst_request_ready,
  input  logic                    inst_request_read_enable,
  input  logic [3:0]              inst_request_write_enable,
  input  logic [ADDR_WIDTH-1:0]   inst_request_addr,
  input  logic [31:0]             inst_request_data,
  output logic                    inst_result_valid,
  input  logic                    inst_result_ready,
  output logic [31:0]             inst_result_data,
  input  logic                    data_request_valid,
  output logic                    data_request_ready,
  input  logic                    data_request_read_enable,
  input  logic [3:0]              data_request_write_enable,
  input  logic [ADDR_WIDTH-1:0]   data_request_addr,
  input  logic [31:0]             data_request_data,
  output logic                    data_result_valid,
  input  logic                    data_result_ready,
  output logic [31:0]             data_result_data,
  output logic                    mem_request_valid,
  input  logic                    mem_request_ready,
  output logic                    mem_request_read_enable,
  output logic [3:0]              mem_request_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_request_addr,
  output logic [31:0]             mem_request_data,
  input  logic                    mem_result_valid,
  output logic                    mem_result_ready,
  input  logic [31:0]             mem_result_data
);
  gecko_mem_src_t last_src, grant_src, head_src;
  logic can_load, grant, sel_data, fifo_empty, fifo_full, head_tag, res_ok, mem_result_fire;
  always_comb begin
    can_load = !mem_request_valid || mem_request_ready;
    grant_src = rr_pick(last_src, inst_request_valid, data_request_valid);
    sel_data = grant_src == GECKO_MEM_SRC_DATA;
    grant = rst && can_load && !fifo_full && (inst_request_valid || data_request_valid);
    inst_request_ready = grant && !sel_data;
    data_request_ready = grant && sel_data;
    head_src = gecko_mem_src_t'(head_tag);
    res_ok = rst && !fifo_empty;
    inst_result_valid = res_ok && mem_result_valid && head_src == GECKO_MEM_SRC_INST;
    data_result_valid = res_ok && mem_result_valid && head_src == GECKO_MEM_SRC_DATA;
    inst_result_data = mem_result_data;
    data_result_data = mem_result_data;
    mem_result_ready = res_ok && (head_src == GECKO_MEM_SRC_DATA ? data_result_ready : inst_result_ready);
    mem_result_fire = mem_result_valid && mem_result_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_request_valid <= 1'b0;
      last_src <= GECKO_MEM_SRC_INST;
    end else begin
      if (can_load) mem_request_valid <= grant;
      if (grant) last_src <= grant_src;
    end
  end
  // payload needs no reset: it is only observed while mem_request_valid is high
  always_ff @(posedge clk)
    if (grant) begin
      mem_request_read_enable <= sel_data ? data_request_read_enable : inst_request_read_enable;
      mem_request_write_enable <= sel_data ? data_request_write_enable : inst_request_write_enable;
      mem_request_addr <= sel_data ? data_request_addr : inst_request_addr;
      mem_request_data <= sel_data ? data_request_data : inst_request_data;
    end
  gecko_mem_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant),
    .push_tag (grant_src),
    .pop      (mem_result_fire),
    .head_tag (head_tag),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );
endmodule

// File: doc/gecko_mem_arbiter.md
GECKO_MEM_ARBITER -- requirements
Module: gecko_mem_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum requests accepted but not yet answered; SHALL be a power of two, >= 2.
REQ-002 Parameter ADDR_WIDTH, default 32: address width of all three request ports.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 inst_request  std_mem_intf.in  32b addr/data  instruction fetch requests from core fetch stage.
REQ-006 inst_result  std_mem_intf.out  32b data  instruction read results back to core decode stage.
REQ-007 data_request  std_mem_intf.in  32b addr/data  load/store requests from core execute stage.
REQ-008 data_result  std_mem_intf.out  32b data  load/store results back to core memory path.
REQ-009 mem_request  std_mem_intf.out  32b addr/data  merged request stream to the single shared memory port.
REQ-010 mem_result  std_mem_intf.in  32b data  in-order results from shared memory, exactly one per accepted mem_request.

Function
REQ-011 Every transfer SHALL use valid/ready; a beat completes only in a cycle where both are high.
REQ-012 Request fields (read_enable, write_enable, addr, data) SHALL pass unmodified from the granted source to mem_request.
REQ-013 mem_request SHALL be driven from a one-entry output register; request-to-mem_request latency is exactly 1 cycle.
REQ-014 The output register SHALL load when it is empty or is being drained in the same cycle (full throughput, one grant per cycle).
REQ-015 A grant SHALL occur only when the output register can load and the outstanding count is below MAX_OUTSTANDING.
REQ-016 Arbitration SHALL be round-robin: with both sources valid, the source not granted most recently wins; after reset, data wins first.
REQ-017 Only the granted source SHALL see ready high; the other source's ready SHALL be low that cycle.
REQ-018 Each grant SHALL push a 1-bit source tag (0 = inst, 1 = data) into an in-order tag FIFO of depth MAX_OUTSTANDING.
REQ-019 Outstanding count SHALL increment on grant, decrement on mem_result beat, stay unchanged when both occur in one cycle.
REQ-020 mem_result SHALL be routed combinationally to the result port selected by the FIFO head tag; the other result port's valid SHALL be low.
REQ-021 mem_result.ready SHALL equal the ready of the selected result port; the tag SHALL pop on the completed beat.
REQ-022 With the FIFO empty, both result valids and mem_result.ready SHALL be low.
REQ-023 At count = MAX_OUTSTANDING, both request readys SHALL be low, even if the same-cycle response would free a slot (no same-cycle pass-through of credit).
REQ-024 FIFO read/write pointers SHALL be log2(MAX_OUTSTANDING) bits and wrap modulo MAX_OUTSTANDING; the count SHALL be one bit wider.
REQ-025 A held mem_request SHALL keep valid and all fields stable until accepted.

Reset
REQ-026 While rst is low: output register empty, mem_request.valid = 0, inst_request.ready = data_request.ready = 0, count = 0, pointers = 0, round-robin state = favor data.
REQ-027 Reset mid-operation SHALL discard all outstanding tags; any mem_result beats for pre-reset requests are the memory's responsibility and not routed.

Structure
REQ-028 Source tag enum (GECKO_MEM_SRC_INST, GECKO_MEM_SRC_DATA) SHALL live in package gecko.
REQ-029 The tag FIFO SHALL be a separate sub-module, gecko_mem_tag_fifo, parameterized by depth.

Verification
REQ-030 Only inst_request valid, addr 0x100 read, memory answers 0xDEADBEEF after 1 cycle -> mem_request valid 1 cycle later with addr 0x100; inst_result.data = 0xDEADBEEF; data_result.valid never high.
REQ-031 Both sources valid every cycle, memory always ready -> grants alternate data, inst, data, inst…; results return on matching ports in issue order.
REQ-032 mem_result stalled, MAX_OUTSTANDING = 4 -> exactly 4 requests issued, then both request readys low; releasing one result re-enables a grant on the next cycle, not the same cycle.
REQ-033 data_result.ready low while head tag = data, inst result next in FIFO -> mem_result.ready low; inst_result.valid stays low (no reordering).
REQ-034 mem_request.ready held low 5 cycles with a pending store to 0x200, write_enable 0xF, data 0x12345678 -> fields unchanged all 5 cycles; no additional grant.
REQ-035 rst pulsed low with 3 requests outstanding -> next cycle count = 0, all valids/readys low; first post-reset request granted to data when both valid.
